// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO controller: register byte offsets, bus FSM
// state encoding and the offset decoder used by the register file.
package gpio_ctrl_pkg;

    // Register byte offsets inside the 32 B window.
    localparam logic [7:0] GPIO_DIN  = 8'h00;  // RO  debounced inputs
    localparam logic [7:0] GPIO_DOUT = 8'h04;  // RW  output register
    localparam logic [7:0] GPIO_DSET = 8'h08;  // WO  DOUT |= wdata
    localparam logic [7:0] GPIO_DCLR = 8'h0C;  // WO  DOUT &= ~wdata
    localparam logic [7:0] GPIO_IE   = 8'h10;  // RW  interrupt enable
    localparam logic [7:0] GPIO_IPOL = 8'h14;  // RW  1=rising, 0=falling
    localparam logic [7:0] GPIO_IS   = 8'h18;  // RW1C edge status

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StResp = 1'b1
    } bus_state_e;

    // One-hot register select; all zero means unmapped.
    typedef struct packed {
        logic din;
        logic dout;
        logic dset;
        logic dclr;
        logic ie;
        logic ipol;
        logic stat;
    } reg_sel_t;

    // Decode a word-aligned byte offset into a register select.
    function automatic reg_sel_t decode_offset(input logic [7:0] off);
        reg_sel_t sel;
        sel = '0;
        case (off)
            GPIO_DIN:  sel.din  = 1'b1;
            GPIO_DOUT: sel.dout = 1'b1;
            GPIO_DSET: sel.dset = 1'b1;
            GPIO_DCLR: sel.dclr = 1'b1;
            GPIO_IE:   sel.ie   = 1'b1;
            GPIO_IPOL: sel.ipol = 1'b1;
            GPIO_IS:   sel.stat = 1'b1;
            default:   sel      = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin input conditioner: 2-FF synchroniser followed by a debouncer.
// A synchronised value that differs from the accepted (stable) value must
// persist for DEB_CYC consecutive cycles before it replaces the stable value.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   pin_i    raw asynchronous pin
//   stable_o debounced pin value
module gpio_debounce
    import gpio_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic stable_o
);

    // Counter only ever holds 0..DEB_CYC-1.
    localparam int unsigned    CntW    = $clog2(DEB_CYC);
    localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYC - 1);

    logic            meta_q;
    logic            sync_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            // This cycle would be the DEB_CYC-th mismatch: accept the new level.
            stable_d = sync_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= pin_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller on the data-side bus. Debounces inputs,
// drives registered outputs and raises a level interrupt on selected edges.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   bus_req/we     access request (held until bus_ready) and direction
//   bus_addr       byte address within the 32 B window, bits[1:0] ignored
//   bus_wdata      full-word write data
//   bus_ready      one-cycle response strobe
//   bus_rdata      read data, valid with bus_ready
//   bus_err        unmapped offset, valid with bus_ready
//   gpio_pin_in    raw board inputs
//   gpio_pin_out   board outputs (= DOUT)
//   irq            level interrupt, |(IS & IE)
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int unsigned IN_W    = 13,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DEB_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic              bus_ready,
    output logic [31:0]       bus_rdata,
    output logic              bus_err,
    input  logic [IN_W-1:0]   gpio_pin_in,
    output logic [OUT_W-1:0]  gpio_pin_out,
    output logic              irq
);

    // ---------------------------------------------------------------- inputs
    logic [IN_W-1:0] din;

    for (genvar i = 0; i < IN_W; i++) begin : g_deb
        gpio_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .pin_i    (gpio_pin_in[i]),
            .stable_o (din[i])
        );
    end

    // ------------------------------------------------------------- state
    bus_state_e       state_q, state_d;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic [IN_W-1:0]  ie_q, ie_d;
    logic [IN_W-1:0]  ipol_q, ipol_d;
    logic [IN_W-1:0]  is_q, is_d;
    logic [IN_W-1:0]  din_prev_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    // ------------------------------------------------------------ decode
    logic [31:0] addr_ext;
    logic [7:0]  off_word;
    logic        addr_in_range;
    reg_sel_t    sel;
    logic        mapped;

    assign addr_ext      = 32'(bus_addr);
    assign off_word      = addr_ext[7:0] & 8'hFC;
    assign addr_in_range = (addr_ext[31:8] == 24'd0);
    assign sel           = addr_in_range ? decode_offset(off_word) : '0;
    assign mapped        = |sel;

    // Write-data bits above the widest register have no destination.
    logic unused_wdata;
    assign unused_wdata = ^bus_wdata;

    logic [OUT_W-1:0] wdata_out;
    logic [IN_W-1:0]  wdata_in;
    assign wdata_out = bus_wdata[OUT_W-1:0];
    assign wdata_in  = bus_wdata[IN_W-1:0];

    // Read mux; write-only registers read as zero.
    logic [31:0] rd_word;
    always_comb begin
        rd_word = '0;
        if (sel.din)  rd_word = 32'(din);
        if (sel.dout) rd_word = 32'(dout_q);
        if (sel.ie)   rd_word = 32'(ie_q);
        if (sel.ipol) rd_word = 32'(ipol_q);
        if (sel.stat) rd_word = 32'(is_q);
    end

    // ------------------------------------------------------- edge detect
    logic [IN_W-1:0] rise;
    logic [IN_W-1:0] fall;
    logic [IN_W-1:0] edge_hit;

    assign rise     = din & ~din_prev_q;
    assign fall     = ~din & din_prev_q;
    assign edge_hit = (rise & ipol_q) | (fall & ~ipol_q);

    // ------------------------------------------------ bus FSM + reg file
    logic [IN_W-1:0] w1c;

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        ie_d    = ie_q;
        ipol_d  = ipol_q;
        rdata_d = '0;
        err_d   = 1'b0;
        w1c     = '0;

        unique case (state_q)
            StIdle: begin
                if (bus_req) begin
                    state_d = StResp;
                    if (!mapped) begin
                        err_d = 1'b1;
                    end else if (bus_we) begin
                        if (sel.dout) dout_d = wdata_out;
                        if (sel.dset) dout_d = dout_q | wdata_out;
                        if (sel.dclr) dout_d = dout_q & ~wdata_out;
                        if (sel.ie)   ie_d   = wdata_in;
                        if (sel.ipol) ipol_d = wdata_in;
                        if (sel.stat) w1c    = wdata_in;
                    end else begin
                        rdata_d = rd_word;
                    end
                end
            end
            StResp: begin
                // Any request seen here is ignored; it is re-sampled in IDLE.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A fresh edge beats a same-cycle clear.
        is_d = (is_q & ~w1c) | edge_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            dout_q     <= '0;
            ie_q       <= '0;
            ipol_q     <= '0;
            is_q       <= '0;
            din_prev_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dout_q     <= dout_d;
            ie_q       <= ie_d;
            ipol_q     <= ipol_d;
            is_q       <= is_d;
            din_prev_q <= din;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // ----------------------------------------------------------- outputs
    assign bus_ready    = (state_q == StResp);
    assign bus_rdata    = rdata_q;
    assign bus_err      = err_q;
    assign gpio_pin_out = dout_q;
    assign irq          = |(is_q & ie_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl with DEB_CYC=4. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_gpio_ctrl;

    localparam int unsigned IN_W    = 13;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DEB_CYC = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              bus_req = 1'b0;
    logic              bus_we = 1'b0;
    logic [ADDR_W-1:0] bus_addr = '0;
    logic [31:0]       bus_wdata = '0;
    logic              bus_ready;
    logic [31:0]       bus_rdata;
    logic              bus_err;
    logic [IN_W-1:0]   gpio_pin_in = '0;
    logic [OUT_W-1:0]  gpio_pin_out;
    logic              irq;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    gpio_ctrl #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .ADDR_W  (ADDR_W),
        .DEB_CYC (DEB_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata),
        .bus_err      (bus_err),
        .gpio_pin_in  (gpio_pin_in),
        .gpio_pin_out (gpio_pin_out),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // One access: request sampled on the next rising edge, ready expected on
    // exactly the following cycle, request dropped in the ready cycle.
    task automatic bus_xfer(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err);
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = addr[ADDR_W-1:0];
        bus_wdata = wd;
        check("ready_before_req", 32'(bus_ready), 32'd0);
        tick(1);
        check("ready_after_req", 32'(bus_ready), 32'd1);
        rd        = bus_rdata;
        err       = bus_err;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_wdata = '0;
        tick(1);
        check("ready_one_cycle", 32'(bus_ready), 32'd0);
    endtask

    task automatic reg_wr(input string tag, input logic [7:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        logic        err;
        bus_xfer(1'b1, addr, wd, rd, err);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic reg_rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        err;
        bus_xfer(1'b0, addr, 32'd0, rd, err);
        check(tag, rd, exp);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          n_ready;

        // ---- reset, then reset again in the middle of a DOUT=0xFF write
        #1 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = 5'h04;
        bus_wdata = 32'hFF;
        tick(1);
        check("dout_before_rst", 32'(gpio_pin_out), 32'hFF);
        rst_n   = 1'b0;
        bus_req = 1'b0;
        bus_we  = 1'b0;
        #1;
        check("dout_async_rst", 32'(gpio_pin_out), 32'h00);
        @(negedge clk);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("rst_pin_out", 32'(gpio_pin_out), 32'h00);
        check("rst_ready", 32'(bus_ready), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_err", 32'(bus_err), 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        reg_rd("rst_din", 8'h00, 32'h0);
        reg_rd("rst_is", 8'h18, 32'h0);

        // ---- DOUT / DSET / DCLR
        reg_wr("wr_dout", 8'h04, 32'hA5);
        check("pin_out_a5", 32'(gpio_pin_out), 32'hA5);
        reg_wr("wr_dset", 8'h08, 32'h0A);
        check("pin_out_af", 32'(gpio_pin_out), 32'hAF);
        reg_wr("wr_dclr", 8'h0C, 32'h81);
        check("pin_out_2e", 32'(gpio_pin_out), 32'h2E);
        reg_rd("rd_dout", 8'h04, 32'h2E);
        reg_rd("rd_dset_wo", 8'h08, 32'h0);

        // ---- interrupt configuration for bit 3, rising edge
        reg_wr("wr_ie", 8'h10, 32'h0008);
        reg_wr("wr_ipol", 8'h14, 32'h0008);
        reg_rd("rd_ie", 8'h10, 32'h0008);
        reg_rd("rd_ipol", 8'h14, 32'h0008);

        // ---- 3-cycle glitch on bit 5 never reaches DIN or IS
        gpio_pin_in[5] = 1'b1;
        tick(3);
        gpio_pin_in[5] = 1'b0;
        tick(12);
        reg_rd("glitch_din", 8'h00, 32'h0);
        reg_rd("glitch_is", 8'h18, 32'h0);

        // ---- bit 3 rises: DIN updates on edge 6, IS on edge 7 after the change
        gpio_pin_in[3] = 1'b1;
        tick(4);
        reg_rd("din_edge5", 8'h00, 32'h0);     // captured on edge 5
        check("irq_edge6", 32'(irq), 32'd0);
        reg_rd("din_edge7", 8'h00, 32'h0008);  // captured on edge 7
        check("irq_rise", 32'(irq), 32'd1);
        reg_rd("is_rise", 8'h18, 32'h0008);

        // ---- W1C clears status and interrupt
        reg_wr("w1c_is", 8'h18, 32'h0008);
        check("irq_cleared", 32'(irq), 32'd0);
        reg_rd("is_cleared", 8'h18, 32'h0);

        // ---- falling edge with IPOL=1 does not set status
        gpio_pin_in[3] = 1'b0;
        tick(12);
        reg_rd("din_fall", 8'h00, 32'h0);
        reg_rd("is_fall", 8'h18, 32'h0);
        check("irq_fall", 32'(irq), 32'd0);

        // ---- W1C coinciding with a new rising edge: set wins
        gpio_pin_in[3] = 1'b1;
        tick(12);
        check("irq_rise2", 32'(irq), 32'd1);
        gpio_pin_in[3] = 1'b0;
        tick(12);
        gpio_pin_in[3] = 1'b1;
        tick(6);
        reg_wr("w1c_race", 8'h18, 32'h0008);   // sampled on edge 7, same as the new edge
        check("irq_race", 32'(irq), 32'd1);
        reg_rd("is_race", 8'h18, 32'h0008);

        // ---- unmapped offset
        bus_xfer(1'b0, 8'h1C, 32'd0, rd, err);
        check("unmapped_rd_err", 32'(err), 32'd1);
        check("unmapped_rd_data", rd, 32'd0);
        bus_xfer(1'b1, 8'h1C, 32'hFFFF_FFFF, rd, err);
        check("unmapped_wr_err", 32'(err), 32'd1);
        check("unmapped_pin_out", 32'(gpio_pin_out), 32'h2E);
        reg_rd("unmapped_ie", 8'h10, 32'h0008);
        reg_rd("unmapped_ipol", 8'h14, 32'h0008);
        reg_rd("unmapped_is", 8'h18, 32'h0008);

        // ---- req held high: one ready every two cycles
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = 5'h00;
        n_ready  = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (bus_ready) n_ready++;
            if (i == 0) check("b2b_first_data", bus_rdata, 32'h0008);
        end
        check("b2b_ready_count", 32'(n_ready), 32'd3);
        bus_req = 1'b0;
        tick(1);
        check("b2b_idle", 32'(bus_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
